// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed FIFO controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default geometry, RAM op select enum and output-stage enum.
package ram_fifo_pkg;

    localparam int RAM_FIFO_ADDR_W = 4;
    localparam int RAM_FIFO_DATA_W = 8;

    // Which operation owns the shared RAM address port this cycle.
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_e;

    // Output stage: holds the head entry presented on pop_data.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/ram_sp_16x8.sv
// Single-port synchronous RAM, one read or write per cycle.
// Latency: dout valid one cycle after rd; dout holds its value while rd=0.
// Backpressure: none; the caller must never assert rd and wr together.
//
// Ports: clk; rd/wr strobes; addr; din write data; dout registered read data.
module ram_sp_16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[addr] <= din;
        end
        if (rd) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port synchronous RAM plus a one-entry output stage.
// Latency: push accepted in t -> ram_rd in t+1 -> pop_valid in t+2; pops every 2 cycles
//          (every cycle when RAM_FIFO_LOOKAHEAD_EN is defined).
// Backpressure: push_ready drops when the RAM is full or a read owns the address port.
//
// Ports:
//   clk, rst (synchronous, active-high), flush (synchronous clear of FIFO state)
//   push_valid/push_ready/push_data : producer handshake
//   pop_valid/pop_ready/pop_data    : consumer handshake, pop_data wired from ram_dout
//   level                           : entries held, RAM plus output stage (0..DEPTH+1)
//   ram_rd/ram_wr/ram_addr/ram_din/ram_dout : RAM strobe interface
// Build option: define RAM_FIFO_LOOKAHEAD_EN to let a pop handshake trigger the next
// RAM read in the same cycle (adds pop_ready -> ram_rd/ram_addr/push_ready paths).
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_W = RAM_FIFO_ADDR_W,
    parameter int DATA_W = RAM_FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    input  logic              pop_ready,
    output logic [ADDR_W:0]   level,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_count;
    out_state_e        out_state;
    out_state_e        out_state_nxt;
    op_e               op;
    logic              blocked;
    logic              ram_empty;
    logic              ram_full;
    logic              rd_want;

    // Reset or flush cycles issue no RAM ops and accept nothing; holding push_ready
    // low during flush keeps the producer from believing a discarded push landed.
    assign blocked   = rst | flush;
    assign ram_empty = (ram_count == '0);
    assign ram_full  = (ram_count == FULL_CNT);
    assign pop_valid = (out_state == OUT_FULL);

`ifdef RAM_FIFO_LOOKAHEAD_EN
    // Refill the output stage in the same cycle it is being drained.
    assign rd_want = !ram_empty && (!pop_valid || pop_ready);
`else
    // Read decision depends on registered state only.
    assign rd_want = !ram_empty && !pop_valid;
`endif

    // One RAM op per cycle; read wins so the output stage never starves.
    always_comb begin
        op = OP_IDLE;
        if (!blocked) begin
            if (rd_want) begin
                op = OP_RD;
            end else if (push_valid && !ram_full) begin
                op = OP_WR;
            end
        end
    end

    assign push_ready = !blocked && (op != OP_RD) && !ram_full;
    assign ram_rd     = (op == OP_RD);
    assign ram_wr     = (op == OP_WR);
    assign ram_addr   = (op == OP_RD) ? rd_ptr : wr_ptr;
    assign ram_din    = push_data;
    assign pop_data   = ram_dout;
    assign level      = ram_count + {{ADDR_W{1'b0}}, pop_valid};

    // Output stage next state: a read always fills it (even while being popped),
    // otherwise a pop handshake empties it.
    always_comb begin
        out_state_nxt = out_state;
        if (op == OP_RD) begin
            out_state_nxt = OUT_FULL;
        end else if (pop_valid && pop_ready) begin
            out_state_nxt = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_state <= OUT_EMPTY;
        end else begin
            out_state <= out_state_nxt;
        end
    end

    // Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
        end else begin
            case (op)
                OP_WR: begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    ram_count <= ram_count + 1'b1;
                end
                OP_RD: begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    ram_count <= ram_count - 1'b1;
                end
                default: begin
                    wr_ptr    <= wr_ptr;
                    rd_ptr    <= rd_ptr;
                    ram_count <= ram_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl connected to the 16x8 single-port RAM.
// Latency: inputs driven 1ns after posedge, outputs sampled 2ns after posedge.
// Backpressure: producer retries while push_ready is low.
module tb_ram_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
`ifdef RAM_FIFO_LOOKAHEAD_EN
    localparam int POP_GAP = 1;
`else
    localparam int POP_GAP = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_ready;
    logic [AW:0]   level;
    logic          ram_rd;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
        .level(level),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    ram_sp_16x8 #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
        .clk(clk), .rd(ram_rd), .wr(ram_wr), .addr(ram_addr),
        .din(ram_din), .dout(ram_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Push n values base, base+1, ... retrying until each is accepted.
    task automatic push_n(input int n, input logic [DW-1:0] base);
        int i = 0;
        int cyc = 0;
        logic acc;
        push_valid = 1'b1;
        while (i < n && cyc < 200) begin
            push_data = base + DW'(i);
            #1;
            acc = push_ready;
            tick();
            if (acc) i++;
            cyc++;
        end
        push_valid = 1'b0;
        n_cmp++;
        if (i != n) begin n_bad++; $display("FAIL push_n_timeout: accepted %0d want %0d", i, n); end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; pop_ready = 1'b0; push_valid = 1'b1; push_data = 8'h3C;
        tick();
        #1;
        n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL rst_push_ready: got %0b want 0", push_ready); end
        n_cmp++; if (ram_wr !== 1'b0) begin n_bad++; $display("FAIL rst_ram_wr: got %0b want 0", ram_wr); end
        n_cmp++; if (ram_rd !== 1'b0) begin n_bad++; $display("FAIL rst_ram_rd: got %0b want 0", ram_rd); end
        tick();
        rst = 1'b0; push_valid = 1'b0;
        #1;
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", level); end
        n_cmp++; if (pop_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pop_valid: got %0b want 0", pop_valid); end
        n_cmp++; if (push_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_push_ready: got %0b want 1", push_ready); end
    endtask

    task automatic test_single_push();
        do_reset();
        push_valid = 1'b1; push_data = 8'hA5;
        #1;
        n_cmp++; if (ram_wr !== 1'b1 || ram_rd !== 1'b0 || ram_addr !== 4'd0 || ram_din !== 8'hA5) begin
            n_bad++; $display("FAIL single_c0: wr=%0b rd=%0b addr=%0d din=%h want wr=1 rd=0 addr=0 din=a5", ram_wr, ram_rd, ram_addr, ram_din); end
        tick();
        push_valid = 1'b0;
        #1;
        n_cmp++; if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 4'd0 || pop_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_c1: rd=%0b wr=%0b addr=%0d pop_valid=%0b want rd=1 wr=0 addr=0 pop_valid=0", ram_rd, ram_wr, ram_addr, pop_valid); end
        tick();
        #1;
        n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'hA5 || level !== 5'd1) begin
            n_bad++; $display("FAIL single_c2: pop_valid=%0b data=%h level=%0d want 1 a5 1", pop_valid, pop_data, level); end
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        #1;
        n_cmp++; if (pop_valid !== 1'b0 || level !== 5'd0) begin
            n_bad++; $display("FAIL single_popped: pop_valid=%0b level=%0d want 0 0", pop_valid, level); end
    endtask

    task automatic test_fill_drain();
        int got = 0;
        int last = 0;
        int cyc = 0;
        do_reset();
        push_n(17, 8'h00);
        push_valid = 1'b1; push_data = 8'hFF;
        #1;
        n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL full_push_ready: got %0b want 0", push_ready); end
        n_cmp++; if (level !== 5'd17) begin n_bad++; $display("FAIL full_level: got %0d want 17", level); end
        n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'h00) begin
            n_bad++; $display("FAIL full_head: pop_valid=%0b data=%h want 1 00", pop_valid, pop_data); end
        tick();
        push_valid = 1'b0;
        pop_ready = 1'b1;
        while (got < 17 && cyc < 100) begin
            #1;
            if (pop_valid) begin
                n_cmp++; if (pop_data !== DW'(got)) begin n_bad++; $display("FAIL drain_order: got %h want %h", pop_data, DW'(got)); end
                if (got > 0) begin
                    n_cmp++; if (cyc - last != POP_GAP) begin n_bad++; $display("FAIL drain_gap: got %0d want %0d", cyc - last, POP_GAP); end
                end
                last = cyc;
                got++;
            end
            tick();
            cyc++;
        end
        pop_ready = 1'b0;
        n_cmp++; if (got != 17) begin n_bad++; $display("FAIL drain_count: got %0d want 17", got); end
        #1;
        n_cmp++; if (level !== 5'd0 || pop_valid !== 1'b0) begin
            n_bad++; $display("FAIL drain_empty: level=%0d pop_valid=%0b want 0 0", level, pop_valid); end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        int wraps = 0;
        int cyc = 0;
        logic acc;
        do_reset();
        pop_ready = 1'b1;
        while (popped < 40 && cyc < 400) begin
            push_valid = (pushed < 40);
            push_data = 8'h40 + DW'(pushed);
            #1;
            acc = push_valid && push_ready;
            n_cmp++; if (ram_wr !== acc) begin n_bad++; $display("FAIL wrap_wr_strobe: got %0b want %0b", ram_wr, acc); end
            if (ram_wr) begin
                n_cmp++; if (ram_addr !== AW'(pushed % 16)) begin n_bad++; $display("FAIL wrap_addr: got %0d want %0d", ram_addr, pushed % 16); end
                if (pushed > 0 && ram_addr == 4'd0) wraps++;
            end
            if (pop_valid) begin
                n_cmp++; if (pop_data !== 8'h40 + DW'(popped)) begin n_bad++; $display("FAIL wrap_order: got %h want %h", pop_data, 8'h40 + DW'(popped)); end
                popped++;
            end
            tick();
            if (acc) pushed++;
            cyc++;
        end
        push_valid = 1'b0; pop_ready = 1'b0;
        n_cmp++; if (pushed != 40 || popped != 40) begin n_bad++; $display("FAIL wrap_counts: pushed=%0d popped=%0d want 40 40", pushed, popped); end
        n_cmp++; if (wraps != 2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", wraps); end
        #1;
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL wrap_level: got %0d want 0", level); end
    endtask

    task automatic test_push_held();
        int cyc = 0;
        do_reset();
        push_valid = 1'b1; push_data = 8'h11;
        #1;
        n_cmp++; if (ram_wr !== 1'b1) begin n_bad++; $display("FAIL held_first_wr: got %0b want 1", ram_wr); end
        tick();
        push_data = 8'h22;
        #1;
        n_cmp++; if (ram_rd !== 1'b1 || push_ready !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 4'd0) begin
            n_bad++; $display("FAIL held_blocked: rd=%0b push_ready=%0b wr=%0b addr=%0d want 1 0 0 0", ram_rd, push_ready, ram_wr, ram_addr); end
        tick();
        #1;
        n_cmp++; if (ram_wr !== 1'b1 || push_ready !== 1'b1 || ram_din !== 8'h22 || ram_addr !== 4'd1) begin
            n_bad++; $display("FAIL held_retry: wr=%0b push_ready=%0b din=%h addr=%0d want 1 1 22 1", ram_wr, push_ready, ram_din, ram_addr); end
        tick();
        push_valid = 1'b0;
        #1;
        n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'h11 || level !== 5'd2) begin
            n_bad++; $display("FAIL held_head: pop_valid=%0b data=%h level=%0d want 1 11 2", pop_valid, pop_data, level); end
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        while (!pop_valid && cyc < 5) begin tick(); cyc++; end
        n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'h22) begin
            n_bad++; $display("FAIL held_second: pop_valid=%0b data=%h want 1 22", pop_valid, pop_data); end
    endtask

    task automatic test_clear(input bit use_rst);
        int cyc = 0;
        do_reset();
        push_n(5, 8'h50);
        #1;
        n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL clear_pre_level: got %0d want 5 (rst=%0b)", level, use_rst); end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        push_valid = 1'b1; push_data = 8'h77;
        #1;
        n_cmp++; if (ram_wr !== 1'b0) begin n_bad++; $display("FAIL clear_wr: got %0b want 0 (rst=%0b)", ram_wr, use_rst); end
        tick();
        rst = 1'b0; flush = 1'b0; push_valid = 1'b0;
        #1;
        n_cmp++; if (level !== 5'd0 || pop_valid !== 1'b0 || ram_rd !== 1'b0) begin
            n_bad++; $display("FAIL clear_state: level=%0d pop_valid=%0b rd=%0b want 0 0 0 (rst=%0b)", level, pop_valid, ram_rd, use_rst); end
        push_valid = 1'b1; push_data = 8'h99;
        #1;
        n_cmp++; if (ram_wr !== 1'b1 || ram_addr !== 4'd0) begin
            n_bad++; $display("FAIL clear_next_wr: wr=%0b addr=%0d want 1 0 (rst=%0b)", ram_wr, ram_addr, use_rst); end
        tick();
        push_valid = 1'b0;
        while (!pop_valid && cyc < 5) begin tick(); cyc++; end
        n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'h99 || level !== 5'd1) begin
            n_bad++; $display("FAIL clear_next_pop: pop_valid=%0b data=%h level=%0d want 1 99 1 (rst=%0b)", pop_valid, pop_data, level, use_rst); end
    endtask

    task automatic test_pop_rate();
        do_reset();
`ifdef RAM_FIFO_LOOKAHEAD_EN
        push_n(8, 8'h80);
        pop_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'h80 + DW'(i)) begin
                n_bad++; $display("FAIL lookahead_pop%0d: pop_valid=%0b data=%h want 1 %h", i, pop_valid, pop_data, 8'h80 + DW'(i)); end
            tick();
        end
`else
        push_n(2, 8'h80);
        pop_ready = 1'b1;
        #1;
        n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'h80) begin
            n_bad++; $display("FAIL rate_first: pop_valid=%0b data=%h want 1 80", pop_valid, pop_data); end
        tick();
        #1;
        n_cmp++; if (pop_valid !== 1'b0 || ram_rd !== 1'b1) begin
            n_bad++; $display("FAIL rate_bubble: pop_valid=%0b rd=%0b want 0 1", pop_valid, ram_rd); end
        tick();
        #1;
        n_cmp++; if (pop_valid !== 1'b1 || pop_data !== 8'h81) begin
            n_bad++; $display("FAIL rate_second: pop_valid=%0b data=%h want 1 81", pop_valid, pop_data); end
        tick();
`endif
        pop_ready = 1'b0;
        #1;
        n_cmp++; if (pop_valid !== 1'b0 || level !== 5'd0) begin
            n_bad++; $display("FAIL rate_empty: pop_valid=%0b level=%0d want 0 0", pop_valid, level); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        #1;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_wrap();
        test_push_held();
        test_clear(1'b0);
        test_clear(1'b1);
        test_pop_rate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO controller sitting directly upstream of the team's 16x8 synchronous single-port RAM.
- Converts a valid/ready push stream and a valid/ready pop stream into the RAM's rd/wr/addr/din strobes.
- Tracks head/tail pointers and occupancy, and presents the RAM's registered dout as pop data.
- One RAM operation per cycle, because the RAM has a single shared address port.

Parameters:
- ADDR_W, 4: RAM address width. DEPTH = 2**ADDR_W is a localparam, 16 by default.
- DATA_W, 8: data width; must match the RAM width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents; no effect on RAM array contents.
- push_valid  in  1  write request.
- push_data  in  DATA_W  write data.
- push_ready  out  1  controller accepts push this cycle.
- pop_valid  out  1  pop_data holds the head entry.
- pop_data  out  DATA_W  head entry; wired directly from ram_dout.
- pop_ready  in  1  consumer takes head entry.
- level  out  ADDR_W+1  entries held = ram_count + pop_valid (0..DEPTH+1).
- ram_rd  out  1  to RAM rd.
- ram_wr  out  1  to RAM wr.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din; equals push_data.
- ram_dout  in  DATA_W  from RAM dout, valid the cycle after ram_rd.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Clock port clk, reset port rst.

Registered state:
- wr_ptr, rd_ptr: ADDR_W bits each, wrap naturally at DEPTH.
- ram_count: ADDR_W+1 bits, 0..DEPTH.
- pop_valid: the output stage. Two states: OUT_EMPTY (pop_valid=0) and OUT_FULL (pop_valid=1).

Reset and flush:
- On rst: pointers=0, ram_count=0, pop_valid=0.
- While rst is high, ram_rd=0, ram_wr=0 and push_ready=0 (forced combinationally).
- flush has the same effect as rst on pointers, count and pop_valid. Any push or pop offered in a flush cycle is ignored.
- rst takes priority over flush.

Per-cycle op select (combinational, at most one op):
- rd_issue = !pop_valid && ram_count!=0.
- wr_issue = push_valid && push_ready.
- push_ready = !rd_issue && ram_count!=DEPTH. Read has priority over write.
- ram_addr = rd_ptr when rd_issue, else wr_ptr.
- A read and a write never occur in the same cycle, so RAM read-during-write never arises.

Edge updates:
- wr_issue: wr_ptr+1, ram_count+1.
- rd_issue: rd_ptr+1, ram_count-1, pop_valid<=1 (OUT_EMPTY->OUT_FULL).
- pop handshake (pop_valid && pop_ready) with no rd_issue: pop_valid<=0 (OUT_FULL->OUT_EMPTY).

Data and timing:
- pop_data = ram_dout. The RAM holds dout while rd=0, and no read is issued while pop_valid=1, so pop_data stays stable until popped.
- Push-to-pop latency on an empty FIFO: push accepted in cycle t, ram_rd in t+1, pop_valid in t+2.
- Sustained pop throughput: 1 entry per 2 cycles.

Boundaries:
- Full: ram_count==DEPTH gives push_ready=0. Total capacity is DEPTH+1, counting the output stage.
- Empty: pop_valid=0, no ram_rd.
- Pointer wrap from 15 to 0 is seamless.
- A push held off by rd_issue must be retried by the producer (valid stays asserted, standard handshake).

Optional Feature:
- Macro: RAM_FIFO_LOOKAHEAD_EN.
- When defined, rd_issue = ram_count!=0 && (!pop_valid || pop_ready). A pop handshake that coincides with a read keeps pop_valid=1, and new data appears the next cycle.
- This gives 1 entry/cycle pop throughput. The cost is combinational paths pop_ready->ram_rd/ram_addr/push_ready.
- When undefined: registered-only read decision as described above, 1 entry per 2 cycles.

Decomposition:
- Package ram_fifo_pkg holds:
  - default ADDR_W=4 and DATA_W=8;
  - the op enum OP_IDLE/OP_WR/OP_RD used for ram_addr muxing;
  - the out-stage enum OUT_EMPTY/OUT_FULL.
- No sub-module is needed; pointer/count logic stays inline.
- The bench instantiates ram_fifo_ctrl together with the existing RAM.

Test Plan:
- Reset then single push 0xA5 at cycle 0 -> ram_wr=1 addr=0 cycle 0; ram_rd=1 addr=0 cycle 1; pop_valid=1, pop_data=0xA5 cycle 2; level=1.
- Push 17 values 0x00..0x10 with pop_ready=0:
  - the first entry is moved to the output stage;
  - push_ready=0 once ram_count=16;
  - level=17;
  - then drain and confirm FIFO order 0x00..0x10 with one pop every 2 cycles.
- Continuous push and pop of 40 values -> addresses wrap 15->0 twice, with no loss or duplication and output order preserved.
- push_valid=1 in the cycle a read issues -> push_ready=0 and ram_wr=0 that cycle; the write lands the next cycle with the same data.
- With FIFO holding 5 entries, assert flush with push_valid=1 -> next cycle level=0, pop_valid=0, and the flushed push is not stored. Repeat with rst for the same result.
- With RAM_FIFO_LOOKAHEAD_EN, preload 8 entries and hold pop_ready=1 -> 8 consecutive pop cycles with pop_valid=1 and no bubbles.
